// File: rtl/mips_io_pkg.sv
// mips_io_pkg: shared constants for the MIPS memory-mapped I/O responder.
//   Offsets are word indices (Address[4:2]) into the 32-byte window.
package mips_io_pkg;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'h1001_0400;

    localparam logic [2:0] IO_PORT_OUT = 3'd0;  // 0x00
    localparam logic [2:0] IO_PORT_IN  = 3'd1;  // 0x04
    localparam logic [2:0] IO_IN_EDGE  = 3'd2;  // 0x08
    localparam logic [2:0] IO_OUT_SET  = 3'd3;  // 0x0C
    localparam logic [2:0] IO_OUT_CLR  = 3'd4;  // 0x10
    localparam logic [2:0] IO_IN_MASK  = 3'd5;  // 0x14

    localparam int WARM_W = 2;

endpackage

// File: rtl/io_input_sync.sv
// io_input_sync: two-flop synchronizer with rising-edge detect gated by a post-reset warm-up counter.
//   clk, reset (sync, active-low) | async_i: raw inputs | sync_o: synchronized inputs | edge_o: rising edges
module io_input_sync
    import mips_io_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] edge_o
);

    logic [WIDTH-1:0]  s1_q, s2_q, prev_q;
    logic [WARM_W-1:0] warm_q, warm_d;

    assign warm_d = (warm_q == '1) ? warm_q : warm_q + 1'b1;
    assign sync_o = s2_q;
    // Inputs already high at reset propagate through s2/prev during warm-up and must not look like edges.
    assign edge_o = (warm_q == '1) ? (s2_q & ~prev_q) : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_q   <= '0;
            s2_q   <= '0;
            prev_q <= '0;
            warm_q <= '0;
        end else begin
            s1_q   <= async_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
            warm_q <= warm_d;
        end
    end

endmodule

// File: rtl/mips_io_responder.sv
// mips_io_responder: memory-mapped output/input port block on the MIPS data-memory bus.
//   clk, reset (sync, active-low) | Address, WriteData, MemWrite, MemRead: processor bus
//   ReadData, Hit: load data and window select | PortIn: async inputs
//   PortOut, PortOutStrobe: output register and change pulse | IRQ: masked edge interrupt
module mips_io_responder
    import mips_io_pkg::*;
#(
    parameter logic [31:0] IO_BASE  = IO_BASE_DEFAULT,
    parameter int          IN_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         Address,
    input  logic [31:0]         WriteData,
    input  logic                MemWrite,
    input  logic                MemRead,
    output logic [31:0]         ReadData,
    output logic                Hit,
    input  logic [IN_WIDTH-1:0] PortIn,
    output logic [31:0]         PortOut,
    output logic                PortOutStrobe,
    output logic                IRQ
);

    logic [2:0]          off;
    logic                wr;
    logic [31:0]         port_out_q, port_out_d, rd_mux;
    logic [IN_WIDTH-1:0] in_edge_q, in_edge_d, in_mask_q, in_mask_d, w1c, sync, edge_det;
    logic                strobe_q;
    logic                unused_addr;

    io_input_sync #(.WIDTH(IN_WIDTH)) u_sync (
        .clk    (clk),
        .reset  (reset),
        .async_i(PortIn),
        .sync_o (sync),
        .edge_o (edge_det)
    );

    assign Hit         = Address[31:5] == IO_BASE[31:5];
    assign off         = Address[4:2];
    assign wr          = Hit & MemWrite;
    assign unused_addr = ^Address[1:0];

    always_comb begin
        port_out_d = (wr && off == IO_PORT_OUT) ? WriteData :
                     (wr && off == IO_OUT_SET)  ? (port_out_q | WriteData) :
                     (wr && off == IO_OUT_CLR)  ? (port_out_q & ~WriteData) : port_out_q;
        w1c        = (wr && off == IO_IN_EDGE) ? WriteData[IN_WIDTH-1:0] : '0;
        // An edge arriving in the same cycle as its W1C must not be lost, so set wins.
        in_edge_d  = (in_edge_q & ~w1c) | edge_det;
        in_mask_d  = (wr && off == IO_IN_MASK) ? WriteData[IN_WIDTH-1:0] : in_mask_q;
        rd_mux     = (off == IO_PORT_OUT) ? port_out_q :
                     (off == IO_PORT_IN)  ? 32'(sync) :
                     (off == IO_IN_EDGE)  ? 32'(in_edge_q) :
                     (off == IO_IN_MASK)  ? 32'(in_mask_q) : '0;
        ReadData   = (Hit & MemRead) ? rd_mux : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            port_out_q <= '0;
            in_edge_q  <= '0;
            in_mask_q  <= '0;
            strobe_q   <= 1'b0;
        end else begin
            port_out_q <= port_out_d;
            in_edge_q  <= in_edge_d;
            in_mask_q  <= in_mask_d;
            strobe_q   <= port_out_d != port_out_q;
        end
    end

    assign PortOut       = port_out_q;
    assign PortOutStrobe = strobe_q;
    assign IRQ           = |(in_edge_q & in_mask_q);

endmodule

// File: tb/tb_mips_io_responder.sv
// tb_mips_io_responder: directed self-checking bench for mips_io_responder.
module tb_mips_io_responder;

    localparam logic [31:0] B = 32'h1001_0400;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] Address = '0;
    logic [31:0] WriteData = '0;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic [31:0] ReadData;
    logic        Hit;
    logic [7:0]  PortIn = '0;
    logic [31:0] PortOut;
    logic        PortOutStrobe;
    logic        IRQ;

    int errors = 0;
    int checks = 0;
    logic [31:0] d;

    mips_io_responder dut (
        .clk          (clk),
        .reset        (reset),
        .Address      (Address),
        .WriteData    (WriteData),
        .MemWrite     (MemWrite),
        .MemRead      (MemRead),
        .ReadData     (ReadData),
        .Hit          (Hit),
        .PortIn       (PortIn),
        .PortOut      (PortOut),
        .PortOutStrobe(PortOutStrobe),
        .IRQ          (IRQ)
    );

    always #5 clk = ~clk;

    // Called at a negedge: presents a store for one rising edge, returns at the following negedge.
    task automatic wr(input logic [31:0] a, input logic [31:0] v);
        Address = a; WriteData = v; MemWrite = 1'b1;
        @(negedge clk);
        MemWrite = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        Address = a; MemRead = 1'b1;
        #1 v = ReadData;
        MemRead = 1'b0;
    endtask

    task automatic test_reset;
        PortIn = 8'hFF;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (PortOut !== 32'h0) begin errors++; $display("FAIL reset_portout got %h exp %h", PortOut, 32'h0); end
        checks++; if (PortOutStrobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b exp 0", PortOutStrobe); end
        reset = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            rd(B + 32'h08, d);
            checks++; if (d !== 32'h0) begin errors++; $display("FAIL warm_in_edge cyc%0d got %h exp %h", i, d, 32'h0); end
            checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL warm_irq cyc%0d got %b exp 0", i, IRQ); end
            if (i >= 2) begin
                rd(B + 32'h04, d);
                checks++; if (d !== 32'h0000_00FF) begin errors++; $display("FAIL warm_port_in cyc%0d got %h exp %h", i, d, 32'hFF); end
            end
        end
        wr(B + 32'h14, 32'hFFFF_FFFF);
        rd(B + 32'h14, d);
        checks++; if (d !== 32'h0000_00FF) begin errors++; $display("FAIL mask_rb got %h exp %h", d, 32'hFF); end
        checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL warm_irq_masked got %b exp 0", IRQ); end
        PortIn = 8'h00;
        wr(B + 32'h14, 32'h0);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_port_out;
        wr(B, 32'hDEAD_BEEF);
        checks++; if (PortOut !== 32'hDEAD_BEEF) begin errors++; $display("FAIL po_write got %h exp %h", PortOut, 32'hDEADBEEF); end
        checks++; if (PortOutStrobe !== 1'b1) begin errors++; $display("FAIL po_strobe got %b exp 1", PortOutStrobe); end
        @(negedge clk);
        checks++; if (PortOutStrobe !== 1'b0) begin errors++; $display("FAIL po_strobe_once got %b exp 0", PortOutStrobe); end
        wr(B + 32'h3, 32'hDEAD_BEEF);
        checks++; if (PortOutStrobe !== 1'b0) begin errors++; $display("FAIL po_same_nostrobe got %b exp 0", PortOutStrobe); end
        rd(B + 32'h1, d);
        checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL po_read got %h exp %h", d, 32'hDEADBEEF); end
    endtask

    task automatic test_set_clr;
        wr(B, 32'h0);
        @(negedge clk);
        wr(B + 32'h0C, 32'h0000_000F);
        checks++; if (PortOut !== 32'hF) begin errors++; $display("FAIL set got %h exp %h", PortOut, 32'hF); end
        checks++; if (PortOutStrobe !== 1'b1) begin errors++; $display("FAIL set_strobe got %b exp 1", PortOutStrobe); end
        wr(B + 32'h10, 32'h0000_0003);
        checks++; if (PortOut !== 32'hC) begin errors++; $display("FAIL clr got %h exp %h", PortOut, 32'hC); end
        checks++; if (PortOutStrobe !== 1'b1) begin errors++; $display("FAIL clr_strobe got %b exp 1", PortOutStrobe); end
        rd(B + 32'h0C, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL set_reads_zero got %h exp %h", d, 32'h0); end
        rd(B + 32'h10, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL clr_reads_zero got %h exp %h", d, 32'h0); end
    endtask

    task automatic test_edge_irq;
        wr(B + 32'h14, 32'h1);
        PortIn = 8'h01;
        @(negedge clk);
        checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL irq_k got %b exp 0", IRQ); end
        @(negedge clk);
        checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL irq_k1 got %b exp 0", IRQ); end
        rd(B + 32'h04, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL port_in_k1 got %h exp %h", d, 32'h1); end
        @(negedge clk);
        checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL irq_k2 got %b exp 1", IRQ); end
        rd(B + 32'h08, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL edge_k2 got %h exp %h", d, 32'h1); end
        @(negedge clk);
        checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL irq_sticky got %b exp 1", IRQ); end
        wr(B + 32'h08, 32'h1);
        checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL irq_w1c got %b exp 0", IRQ); end
        rd(B + 32'h08, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL edge_w1c got %h exp %h", d, 32'h0); end
    endtask

    task automatic test_w1c_race;
        PortIn = 8'h05;
        repeat (2) @(negedge clk);
        wr(B + 32'h08, 32'h4);
        rd(B + 32'h08, d);
        checks++; if (d !== 32'h4) begin errors++; $display("FAIL race_set_wins got %h exp %h", d, 32'h4); end
        checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL race_irq_unmasked got %b exp 0", IRQ); end
        wr(B + 32'h08, 32'h4);
        rd(B + 32'h08, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL race_clear got %h exp %h", d, 32'h0); end
    endtask

    task automatic test_reserved;
        rd(B + 32'h1C, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rsv1c_read got %h exp %h", d, 32'h0); end
        rd(B + 32'h18, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rsv18_read got %h exp %h", d, 32'h0); end
        Address = B + 32'h14; #1;
        checks++; if (Hit !== 1'b1) begin errors++; $display("FAIL hit_in got %b exp 1", Hit); end
        checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL no_memread got %h exp %h", ReadData, 32'h0); end
        rd(32'h1001_0000, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL outside_read got %h exp %h", d, 32'h0); end
        checks++; if (Hit !== 1'b0) begin errors++; $display("FAIL hit_out got %b exp 0", Hit); end
        rd(B + 32'h20, d);
        checks++; if (Hit !== 1'b0) begin errors++; $display("FAIL hit_above got %b exp 0", Hit); end
        @(negedge clk);
        wr(B + 32'h18, 32'hFFFF_FFFF);
        checks++; if (PortOut !== 32'hC) begin errors++; $display("FAIL rsv_write_po got %h exp %h", PortOut, 32'hC); end
        checks++; if (PortOutStrobe !== 1'b0) begin errors++; $display("FAIL rsv_write_strobe got %b exp 0", PortOutStrobe); end
        rd(B + 32'h14, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL rsv_write_mask got %h exp %h", d, 32'h1); end
        wr(32'h1001_0000, 32'h1234_5678);
        checks++; if (PortOut !== 32'hC) begin errors++; $display("FAIL outside_write got %h exp %h", PortOut, 32'hC); end
    endtask

    task automatic test_midreset;
        PortIn = 8'h00;
        repeat (3) @(negedge clk);
        PortIn = 8'h01;
        repeat (3) @(negedge clk);
        checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL pre_reset_irq got %b exp 1", IRQ); end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checks++; if (PortOut !== 32'h0) begin errors++; $display("FAIL midreset_po got %h exp %h", PortOut, 32'h0); end
        checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL midreset_irq got %b exp 0", IRQ); end
        rd(B + 32'h14, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL midreset_mask got %h exp %h", d, 32'h0); end
        rd(B + 32'h08, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL midreset_edge got %h exp %h", d, 32'h0); end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_port_out;
        test_set_clr;
        test_edge_irq;
        test_w1c_race;
        test_reserved;
        test_midreset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
